rwc_gen_vote: RTL
=================

Name: rwc_gen_vote

Overview:
- Parametrised successor to the read-write collision generator controller in the Collision PUF.
- Each accepted challenge (data, address) runs REPEAT write-then-collide evaluations on one true-dual-port BRAM in a single clock domain.
- Accumulates per-bit "1" counts across evaluations and returns a majority-voted response plus an unstable-bit mask.
- Sits between the challenge source (UART/host FSM) and the response collector, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 32, challenge/response width in bits.
- ADDR_W, 10, BRAM address width (depth 2^ADDR_W).
- REPEAT, 7, evaluations per challenge; legal range 1..255.
- CLEAR_VAL, 0, word written on port A during the collision cycle (DATA_W bits).
- SIM_MODE, 0, collision model passed to rwc_dpram: 0 = read-first, 1 = write-first, 2 = alternate (odd-numbered collisions read-first, even-numbered collisions write-first). Ignored by synthesis.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- cha_valid  in  1  challenge offered.
- cha_ready  out  1  high only in IDLE.
- cha_data  in  DATA_W  challenge word.
- cha_addr  in  ADDR_W  BRAM address for this challenge.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  collector accepts response.
- rsp_data  out  DATA_W  majority-voted response.
- rsp_unstable  out  DATA_W  bit i = 1 if the evaluations for bit i were not unanimous.
- rsp_addr  out  ADDR_W  address of the challenge that produced this response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state = IDLE; cha_ready = 1 once rst deasserts; rsp_valid = 0; rsp_data = 0; rsp_unstable = 0; rsp_addr = 0; busy = 0; all counters = 0. BRAM contents are not reset.
- Reset mid-operation aborts immediately and returns to IDLE; no partial response is issued.
- States: IDLE, WRITE, COLLIDE, SAMPLE, RESP.
  - IDLE: if cha_valid, latch cha_data and cha_addr, clear the per-bit counters and the evaluation counter, then go to WRITE.
  - WRITE: port A writes the latched challenge to the latched address; port B is disabled. Next state is COLLIDE.
  - COLLIDE: port A writes CLEAR_VAL to the same address while port B reads that address. Next state is SAMPLE.
  - SAMPLE: doutb is valid (1-cycle synchronous read). Each per-bit counter increments where doutb[i] = 1, and the evaluation counter increments. If the evaluation counter reaches REPEAT, go to RESP; otherwise go back to WRITE.
  - RESP: rsp_valid = 1. On rsp_valid && rsp_ready, go to IDLE.
- Output registers are loaded on the edge entering RESP, using the updated counts:
  - rsp_data[i] = 1 iff 2*cnt[i] > REPEAT (ties give 0).
  - rsp_unstable[i] = 1 iff 0 < cnt[i] < REPEAT.
  - Outputs remain stable while rsp_valid && !rsp_ready.
- Latency: the accept edge enters WRITE. rsp_valid rises exactly 3*REPEAT edges after the accept edge. The earliest next accept is 1 edge after the response handshake (IDLE lasts at least 1 cycle).
- Counter width: clog2(REPEAT+1) bits per data bit, with no saturation needed. The evaluation counter has the same width.
- Port A has write enable only in WRITE and COLLIDE. Port B has read enable only in COLLIDE.
- cha_valid outside IDLE is ignored (not accepted). The cha_data and cha_addr inputs may change freely after the accept edge.

Decomposition:
- Shared package rwc_pkg holds:
  - the state encoding constants;
  - the SIM_MODE encodings;
  - a clog2 function.
- Sub-module rwc_dpram: true-dual-port RAM, DATA_W x 2^ADDR_W, synchronous read.
  - Synthesis: infers BRAM.
  - Simulation: collision output follows SIM_MODE. rwc_dpram keeps its own collision counter for mode 2; that counter resets on rst.
  - rwc_gen_vote instantiates it once, with both ports on clk.

Test Plan:
1. Reset, then idle: assert rst asynchronously mid-cycle -> all outputs reach their reset values without waiting for a clock edge; cha_ready = 1 after release.
2. SIM_MODE=0, REPEAT=7, cha_data=0xA5A5_5A5A, cha_addr=0x3FF -> rsp_valid exactly 21 cycles after accept; rsp_data=0xA5A5_5A5A, rsp_unstable=0, rsp_addr=0x3FF.
3. SIM_MODE=1, REPEAT=7, cha_data=0xFFFF_FFFF -> rsp_data=CLEAR_VAL=0, rsp_unstable=0.
4. SIM_MODE=2, REPEAT=7, cha_data=0x0000_FFFF -> counts are 4 -> rsp_data=0x0000_FFFF, rsp_unstable=0x0000_FFFF. Same test with REPEAT=8 -> ties -> rsp_data=0, rsp_unstable=0x0000_FFFF.
5. Backpressure: hold rsp_ready=0 for 10 cycles, with cha_valid=1 throughout -> outputs stable, cha_ready=0, no second accept. Release rsp_ready -> handshake, then the next accept occurs 1 cycle later.
6. Reset mid-operation: assert rst during the 3rd evaluation -> no rsp_valid. A new challenge 0x1234_5678 after reset -> correct response; its counts are unaffected by the aborted run.

Source files
------------

// File: rtl/rwc_pkg.sv
// Shared definitions for the read-write collision vote generator.
//   - state_t         : controller state encoding
//   - SIM_*           : collision models understood by rwc_dpram
//   - clog2()         : ceiling log2 used to size the vote counters
package rwc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_COLLIDE = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    localparam int unsigned SIM_READ_FIRST  = 0;
    localparam int unsigned SIM_WRITE_FIRST = 1;
    localparam int unsigned SIM_ALTERNATE   = 2;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rwc_dpram.sv
// Dual-port RAM, DATA_W x 2**ADDR_W, one clock, synchronous read.
// Port A writes, port B reads.  When both ports hit the same address in the
// same cycle, the read data follows SIM_MODE (read-first / write-first /
// alternating starting read-first).  Mode 0 is the plain read-first BRAM.
//   clk, rst         : clock, async active-high reset (collision counter only)
//   we_a_i, addr_a_i, din_a_i : port A write
//   en_b_i, addr_b_i, dout_b_o: port B read, data valid one cycle later
module rwc_dpram
    import rwc_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned SIM_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [DATA_W-1:0] din_a_i,
    input  logic              en_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic [DATA_W-1:0] dout_b_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;
    logic              coll_par_q;    // parity of collisions seen since reset
    logic              coll_c;
    logic              write_first_c;

    assign coll_c        = we_a_i && en_b_i && (addr_a_i == addr_b_i);
    // Alternate mode: collision #1,#3,.. read-first, #2,#4,.. write-first.
    assign write_first_c = (SIM_MODE == SIM_WRITE_FIRST) ||
                           ((SIM_MODE == SIM_ALTERNATE) && coll_par_q);

    // Memory array and registered read port.
    always_ff @(posedge clk) begin
        if (we_a_i) begin
            mem_q[addr_a_i] <= din_a_i;
        end
        if (en_b_i) begin
            dout_q <= (coll_c && write_first_c) ? din_a_i : mem_q[addr_b_i];
        end
    end

    // Collision counter (mod 2) for the alternating model.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_par_q <= 1'b0;
        end else if (coll_c) begin
            coll_par_q <= ~coll_par_q;
        end
    end

    assign dout_b_o = dout_q;

endmodule

// File: rtl/rwc_gen_vote.sv
// Read-write collision generator with majority vote.
// Each accepted challenge is written to the BRAM and collided REPEAT times;
// per-bit "1" counts produce a voted response and an unstable-bit mask.
//   cha_valid/cha_ready/cha_data/cha_addr : challenge handshake (ready in IDLE)
//   rsp_valid/rsp_ready                   : response handshake, held until taken
//   rsp_data     : bit = 1 when more than half the evaluations read 1
//   rsp_unstable : bit = 1 when evaluations disagreed
//   rsp_addr     : address of the challenge that produced the response
//   busy         : controller not in IDLE
module rwc_gen_vote
    import rwc_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       REPEAT    = 7,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
    parameter int unsigned       SIM_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cha_valid,
    output logic              cha_ready,
    input  logic [DATA_W-1:0] cha_data,
    input  logic [ADDR_W-1:0] cha_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] rsp_unstable,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy
);

    localparam int unsigned CW = clog2(REPEAT + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     eval_q, eval_d, eval_inc;
    logic [CW-1:0]     cnt_q   [DATA_W];
    logic [CW-1:0]     cnt_d   [DATA_W];
    logic [CW-1:0]     cnt_inc [DATA_W];
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] rsp_unstable_q, rsp_unstable_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic              cha_ready_q, cha_ready_d;
    logic              busy_q, busy_d;
    logic              we_a;
    logic [DATA_W-1:0] din_a;
    logic              en_b;
    logic [DATA_W-1:0] dout_b;

    rwc_dpram #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .SIM_MODE (SIM_MODE)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we_a_i   (we_a),
        .addr_a_i (addr_q),
        .din_a_i  (din_a),
        .en_b_i   (en_b),
        .addr_b_i (addr_q),
        .dout_b_o (dout_b)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cha_valid) state_d = ST_WRITE;
            ST_WRITE:   state_d = ST_COLLIDE;
            ST_COLLIDE: state_d = ST_SAMPLE;
            ST_SAMPLE:  state_d = (eval_q + CW'(1) == CW'(REPEAT)) ? ST_RESP : ST_WRITE;
            ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic: RAM controls and next values of all registers.
    always_comb begin
        data_d         = data_q;
        addr_d         = addr_q;
        eval_d         = eval_q;
        cnt_d          = cnt_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_data_d     = rsp_data_q;
        rsp_unstable_d = rsp_unstable_q;
        rsp_addr_d     = rsp_addr_q;
        we_a           = 1'b0;
        din_a          = data_q;
        en_b           = 1'b0;
        eval_inc       = eval_q + CW'(1);
        for (int unsigned i = 0; i < DATA_W; i++) begin
            cnt_inc[i] = cnt_q[i] + CW'(dout_b[i]);
        end

        case (state_q)
            ST_IDLE: begin
                if (cha_valid) begin
                    data_d = cha_data;
                    addr_d = cha_addr;
                    eval_d = '0;
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        cnt_d[i] = '0;
                    end
                end
            end
            ST_WRITE: begin
                we_a = 1'b1;
            end
            ST_COLLIDE: begin
                we_a  = 1'b1;
                din_a = CLEAR_VAL;
                en_b  = 1'b1;
            end
            ST_SAMPLE: begin
                eval_d = eval_inc;
                cnt_d  = cnt_inc;
                // Last evaluation: vote on the counts including this sample.
                if (eval_inc == CW'(REPEAT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = addr_q;
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        rsp_data_d[i]     = (32'(cnt_inc[i]) << 1) > REPEAT;
                        rsp_unstable_d[i] = (cnt_inc[i] != '0) &&
                                            (cnt_inc[i] != CW'(REPEAT));
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase

        cha_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q         <= '0;
            addr_q         <= '0;
            eval_q         <= '0;
            for (int unsigned i = 0; i < DATA_W; i++) begin
                cnt_q[i] <= '0;
            end
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_unstable_q <= '0;
            rsp_addr_q     <= '0;
            cha_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            data_q         <= data_d;
            addr_q         <= addr_d;
            eval_q         <= eval_d;
            cnt_q          <= cnt_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_unstable_q <= rsp_unstable_d;
            rsp_addr_q     <= rsp_addr_d;
            cha_ready_q    <= cha_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign cha_ready    = cha_ready_q;
    assign busy         = busy_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_unstable = rsp_unstable_q;
    assign rsp_addr     = rsp_addr_q;

endmodule
